// File: rtl/retire_trace_buffer.sv
// -----------------------------------------------------------------------------
// retire_trace_buffer
//
// Commit-trace capture for the RV32I cores. Retired instructions (pc, instr,
// write data) from up to RETIRE_W lanes per cycle go into a circular buffer.
// Capture stops POST_TRIG entries after a trigger. The buffer is then drained
// oldest-first over a valid/ready port.
//
// Optional feature macro: TRACE_FILTER_EN
//   When defined, the trc_class_mask[8:0] input is added. Lanes are captured
//   only if their opcode class bit is set. Unknown opcodes are always
//   captured. Filtered lanes never trigger and never count toward post_cnt.
//
// Parameters
//   RETIRE_W   retire lanes per cycle (1..4), lane 0 oldest
//   DEPTH      buffer entries, power of 2, >= 2*RETIRE_W
//   POST_TRIG  entries captured after the trigger entry, 0..DEPTH-1
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   ret_*                     per-lane retire information (lane i at [i*32 +: 32])
//   trc_class_mask            class filter (TRACE_FILTER_EN only)
//   arm / abort               control pulses
//   trig_in, trig_pc_en/pc    external and pc-match trigger sources
//   rd_valid/rd_ready         readout handshake
//   rd_pc/rd_instr/rd_data    oldest remaining entry
//   rd_last                   current entry is the final one
//   state                     0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
//   ovf_cnt                   overwritten entries, saturating
// -----------------------------------------------------------------------------
module retire_trace_buffer #(
    parameter int RETIRE_W  = 1,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [RETIRE_W-1:0]   ret_valid,
    input  logic [RETIRE_W*32-1:0] ret_pc,
    input  logic [RETIRE_W*32-1:0] ret_instr,
    input  logic [RETIRE_W-1:0]   ret_rd_we,
    input  logic [RETIRE_W*32-1:0] ret_rd_wdata,
    input  logic [RETIRE_W-1:0]   ret_dmem_we,
    input  logic [RETIRE_W*32-1:0] ret_dmem_wd,
`ifdef TRACE_FILTER_EN
    input  logic [8:0]            trc_class_mask,
`endif
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig_in,
    input  logic                  trig_pc_en,
    input  logic [31:0]           trig_pc,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_pc,
    output logic [31:0]           rd_instr,
    output logic [31:0]           rd_data,
    output logic                  rd_last,
    output logic [1:0]            state,
    output logic [15:0]           ovf_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   post_cnt_reg, post_cnt_next;
    logic [15:0]     ovf_cnt_reg, ovf_cnt_next;

    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     data_mem  [DEPTH];

    logic [31:0]     lane_pc    [RETIRE_W];
    logic [31:0]     lane_instr [RETIRE_W];
    logic [31:0]     lane_data  [RETIRE_W];
    logic [RETIRE_W-1:0] class_ok;

    // Per-lane unpacking, entry data selection and class filter.
    for (genvar gi = 0; gi < RETIRE_W; gi++) begin : g_lane
        assign lane_pc[gi]    = ret_pc[gi*32 +: 32];
        assign lane_instr[gi] = ret_instr[gi*32 +: 32];
        assign lane_data[gi]  = ret_rd_we[gi]   ? ret_rd_wdata[gi*32 +: 32] :
                                ret_dmem_we[gi] ? ret_dmem_wd[gi*32 +: 32]  : 32'd0;
`ifdef TRACE_FILTER_EN
        logic lane_ok;
        always_comb begin
            case (lane_instr[gi][6:0])
                7'b0110011: lane_ok = trc_class_mask[0]; // R-type
                7'b0000011: lane_ok = trc_class_mask[1]; // load
                7'b0100011: lane_ok = trc_class_mask[2]; // store
                7'b0010011: lane_ok = trc_class_mask[3]; // op-imm
                7'b1100011: lane_ok = trc_class_mask[4]; // branch
                7'b1101111: lane_ok = trc_class_mask[5]; // jal
                7'b1100111: lane_ok = trc_class_mask[6]; // jalr
                7'b0010111: lane_ok = trc_class_mask[7]; // auipc
                7'b0110111: lane_ok = trc_class_mask[8]; // lui
                default:    lane_ok = 1'b1;              // unknown: keep
            endcase
        end
        assign class_ok[gi] = lane_ok;
`else
        assign class_ok[gi] = 1'b1;
`endif
    end

    // Capture / control datapath
    logic [RETIRE_W-1:0] cap;
    logic [CW-1:0]       pos [RETIRE_W];   // compacted slot of each lane
    logic [CW-1:0]       k, k_eff, trig_pos, n_after, n_post, room, total, ovf_amt;
    logic                pc_hit, capture;
    logic [16:0]         ovf_sum;
    logic [RETIRE_W-1:0] wen;
    logic [PW-1:0]       waddr [RETIRE_W];

    always_comb begin
        cap = ret_valid & class_ok;

        // Compact captured lanes in lane order.
        k = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            pos[i] = k;
            if (cap[i]) k = k + CW'(1);
        end

        // First captured lane whose pc matches is the trigger entry; without a
        // match, trig_in makes the first captured entry (slot 0) the trigger.
        pc_hit   = 1'b0;
        trig_pos = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (!pc_hit && cap[i] && trig_pc_en && (lane_pc[i] == trig_pc)) begin
                pc_hit   = 1'b1;
                trig_pos = pos[i];
            end
        end
        n_after = (k == '0) ? '0 : (k - trig_pos - CW'(1));
        n_post  = (n_after > CW'(POST_TRIG)) ? CW'(POST_TRIG) : n_after;
        room    = CW'(POST_TRIG) - post_cnt_reg;

        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        post_cnt_next = post_cnt_reg;
        ovf_cnt_next  = ovf_cnt_reg;
        capture       = 1'b0;
        k_eff         = '0;
        total         = '0;
        ovf_amt       = '0;
        ovf_sum       = '0;

        case (state_reg)
            S_IDLE: begin
                if (arm) begin
                    state_next    = S_ARMED;
                    wr_ptr_next   = '0;
                    rd_ptr_next   = '0;
                    count_next    = '0;
                    post_cnt_next = '0;
                    ovf_cnt_next  = '0;
                end
            end
            S_ARMED: begin
                capture = 1'b1;
                if (pc_hit || trig_in) begin
                    // Keep everything up to the trigger plus at most POST_TRIG after it.
                    k_eff         = (k == '0) ? '0 : (trig_pos + n_post + CW'(1));
                    post_cnt_next = n_post;
                    state_next    = (n_post == CW'(POST_TRIG)) ? S_FROZEN : S_POST;
                end else begin
                    k_eff = k;
                end
            end
            S_POST: begin
                capture       = 1'b1;
                k_eff         = (k > room) ? room : k;
                post_cnt_next = post_cnt_reg + k_eff;
                if (post_cnt_next == CW'(POST_TRIG)) state_next = S_FROZEN;
            end
            S_FROZEN: begin
                if (count_reg == '0) begin
                    state_next = S_IDLE;
                end else if (rd_ready) begin
                    rd_ptr_next = rd_ptr_reg + PW'(1);
                    count_next  = count_reg - CW'(1);
                    if (count_reg == CW'(1)) state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (capture) begin
            total       = count_reg + k_eff;
            wr_ptr_next = wr_ptr_reg + k_eff[PW-1:0];
            if (total > CW'(DEPTH)) begin
                // Oldest entries are overwritten; readout start moves with them.
                ovf_amt      = total - CW'(DEPTH);
                rd_ptr_next  = rd_ptr_reg + ovf_amt[PW-1:0];
                count_next   = CW'(DEPTH);
                ovf_sum      = {1'b0, ovf_cnt_reg} + 17'(ovf_amt);
                ovf_cnt_next = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
            end else begin
                count_next = total;
            end
        end

        if (abort) begin
            state_next    = S_IDLE;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            post_cnt_next = '0;
            capture       = 1'b0;
        end

        for (int i = 0; i < RETIRE_W; i++) begin
            wen[i]   = capture && cap[i] && (pos[i] < k_eff);
            waddr[i] = wr_ptr_reg + pos[i][PW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            post_cnt_reg <= '0;
            ovf_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            post_cnt_reg <= post_cnt_next;
            ovf_cnt_reg  <= ovf_cnt_next;
        end
    end

    // Storage has no reset; outputs are masked until FROZEN with data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RETIRE_W; i++) begin
            if (wen[i]) begin
                pc_mem[waddr[i]]    <= lane_pc[i];
                instr_mem[waddr[i]] <= lane_instr[i];
                data_mem[waddr[i]]  <= lane_data[i];
            end
        end
    end

    assign rd_valid = (state_reg == S_FROZEN) && (count_reg != '0);
    assign rd_last  = rd_valid && (count_reg == CW'(1));
    assign rd_pc    = rd_valid ? pc_mem[rd_ptr_reg]    : 32'd0;
    assign rd_instr = rd_valid ? instr_mem[rd_ptr_reg] : 32'd0;
    assign rd_data  = rd_valid ? data_mem[rd_ptr_reg]  : 32'd0;
    assign state    = state_reg;
    assign ovf_cnt  = ovf_cnt_reg;

endmodule
